rps_round_ctrl: RTL and testbench
=================================

# rps_round_ctrl

Synchronous round controller for the rock-paper-scissors game. Sits between the three computer players (random, Markov, reinforcement) and the display/score outputs (VGA drawer, hex decoders, LEDs). Debounces the start key, waits for the selected player to be ready, and latches one computer choice per press. It then judges the round, updates saturating scores and emits a one-cycle `round_done` pulse. The learning players consume this pulse to train.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 500000: cycles a key level must be stable to be accepted (10 ms at 50 MHz).
- `SCORE_W`, 8: score counter width.
- `TIMEOUT_CYCLES`, 50000000: ready-wait limit. Used only with `RPS_ROUND_TIMEOUT_EN`.

Ports:
- `CLOCK_50`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `start_n`  in  1  raw KEY, active-low, asynchronous to the clock.
- `user_choice`  in  2  00 rock, 01 scissor, 10 paper, 11 invalid.
- `mode`  in  2  00 random, 01 Markov, 10 reinforce, 11 treated as random.
- `com_ra`, `com_m`, `com_re`  in  2 each  player choices, same encoding as `user_choice`.
- `re_ready`  in  1  reinforcement player has a valid choice.
- `com_loaded`  out  2  latched computer choice.
- `user_loaded`  out  2  latched user choice.
- `user_score`, `com_score`  out  `SCORE_W`  scores.
- `uwin`, `cwin`, `equ`  out  1 each  outcome flags of the last round.
- `round_done`  out  1  one-cycle pulse when a round is judged.
- `busy`  out  1  high in every state except IDLE.

## Operation
- Reset value of every output is 0. FSM resets to IDLE and debouncer state is cleared.
- Debounce:
  - `start_n` passes through a 2-flop synchroniser.
  - Level is accepted after `DEBOUNCE_CYCLES` consecutive equal samples.
  - `press` is a one-cycle pulse on the accepted high-to-low transition.
- FSM states: IDLE, WAIT_RDY, LATCH, JUDGE, HOLD.
  - IDLE: on `press`, go to WAIT_RDY.
  - WAIT_RDY: go to LATCH when `mode`≠10 or `re_ready`=1. Otherwise stay. `mode` is re-evaluated every cycle.
  - LATCH:
    - Capture `com_loaded` from the source selected by `mode`, and `user_loaded`.
    - Clear `uwin`/`cwin`/`equ`.
    - Go to JUDGE.
  - JUDGE: compute the outcome from the latched values, update flags and score, pulse `round_done`, go to HOLD.
  - HOLD: wait for the debounced key to be released (high), then go to IDLE. One round per press regardless of hold time.
- Judging:
  - Rock beats scissor, scissor beats paper, paper beats rock.
  - Win: `uwin`=1, `user_score`+1.
  - Loss: `cwin`=1, `com_score`+1.
  - Equal choices: `equ`=1, no score change.
- Invalid (11) in either latched choice: all flags 0, no score change, `round_done` still pulses.
- Scores saturate at 2^`SCORE_W`−1. No wrap-around.
- Flags and scores hold until the next LATCH or reset.
- Presses arriving while `busy` are ignored. No queueing.
- Reset asserted mid-round aborts the round: no pulse, all outputs 0.

## Timing
- `press` high in cycle N → WAIT_RDY in N+1.
- With ready true in N+1: LATCH in N+2, JUDGE in N+3.
- Flags, scores and `round_done` are registered and visible in N+4. Minimum latency is 4 cycles from `press`.
- `round_done` is exactly one cycle wide, coincident with the first cycle the new scores are visible.
- `com_loaded`/`user_loaded` are stable from N+3 until the next LATCH.
- Key-to-`press` latency is 2 sync cycles + `DEBOUNCE_CYCLES`.

## Configuration
- `RPS_ROUND_TIMEOUT_EN` defined:
  - WAIT_RDY counts cycles.
  - After `TIMEOUT_CYCLES` without `re_ready`, go to LATCH using `com_ra` in place of `com_re`.
  - Counter clears on entry to WAIT_RDY.
- Undefined: WAIT_RDY waits indefinitely. No counter is synthesised.

## Structure
- Shared package `rps_pkg`:
  - Choice encodings ROCK=00, SCISSOR=01, PAPER=10, INVALID=11.
  - Mode encodings.
  - Outcome enum (WIN, LOSE, DRAW, NONE).
  - FSM state enum.
  - A `beats(a,b)` function.
- One sub-module, `key_debouncer`: synchroniser plus stable counter, outputs the accepted level and the `press` pulse. Parameterised by `DEBOUNCE_CYCLES`.

## Test plan
(Bench uses `DEBOUNCE_CYCLES`=4.)
- Reset, then mode 00 with `com_ra`=01 and user 00, press → `uwin`=1, `user_score`=1, `com_loaded`=01, one `round_done` pulse 4 cycles after `press`.
- Mode 10, `re_ready`=0 for 20 cycles then 1, `com_re`=10, user 00 → stays in WAIT_RDY with `busy`=1; then `cwin`=1, `com_score`=1.
- User 11, press → flags all 0, scores unchanged, `round_done` pulses once.
- `user_score` preset to 255 by 255 winning rounds, one more win → `user_score` stays 255.
- Key held 1000 cycles with 3-cycle glitches on release → exactly one `round_done`; a second press during HOLD produces nothing.
- Reset pulsed during JUDGE → all outputs 0, no `round_done`. With `RPS_ROUND_TIMEOUT_EN` and `TIMEOUT_CYCLES`=10: `re_ready`=0, `com_ra`=00, user 10 → `uwin`=1 after timeout.

Source files
------------

// File: rtl/rps_pkg.sv
// rps_pkg
// Shared encodings and helpers for the rock-paper-scissors round controller.
//   choice_t  : ROCK=00, SCISSOR=01, PAPER=10, INVALID=11
//   mode_t    : player select (11 behaves as random)
//   outcome_t : round result seen from the user's side
//   state_t   : round controller FSM states
//   beats()   : 1 when choice a defeats choice b
//   judge()   : full outcome of a user/computer pair
package rps_pkg;

  typedef enum logic [1:0] {
    ROCK    = 2'b00,
    SCISSOR = 2'b01,
    PAPER   = 2'b10,
    INVALID = 2'b11
  } choice_t;

  typedef enum logic [1:0] {
    MODE_RANDOM    = 2'b00,
    MODE_MARKOV    = 2'b01,
    MODE_REINFORCE = 2'b10,
    MODE_RSVD      = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    OUT_WIN  = 2'b00,
    OUT_LOSE = 2'b01,
    OUT_DRAW = 2'b10,
    OUT_NONE = 2'b11
  } outcome_t;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_RDY = 3'd1,
    S_LATCH    = 3'd2,
    S_JUDGE    = 3'd3,
    S_HOLD     = 3'd4
  } state_t;

  function automatic logic beats(input logic [1:0] a, input logic [1:0] b);
    return ((a == ROCK)    && (b == SCISSOR)) ||
           ((a == SCISSOR) && (b == PAPER))   ||
           ((a == PAPER)   && (b == ROCK));
  endfunction

  function automatic outcome_t judge(input logic [1:0] u, input logic [1:0] c);
    outcome_t res;
    if ((u == INVALID) || (c == INVALID)) res = OUT_NONE;
    else if (u == c)                      res = OUT_DRAW;
    else if (beats(u, c))                 res = OUT_WIN;
    else                                  res = OUT_LOSE;
    return res;
  endfunction

endpackage

// File: rtl/key_debouncer.sv
// key_debouncer
// Two-flop synchroniser followed by a stability counter for an active-low key.
// A new level is accepted after DEBOUNCE_CYCLES consecutive samples that
// differ from the current accepted level.
// Ports:
//   CLOCK_50  in  system clock
//   reset     in  asynchronous active-low reset (clears all state)
//   i_key_n   in  raw key, active-low, asynchronous
//   o_level   out accepted (debounced) key level
//   o_press   out one-cycle pulse on accepted high-to-low transition
module key_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic i_key_n,
  output logic o_level,
  output logic o_press
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_press;
  logic [CW-1:0] r_cnt;

  // Level resets low, so a released key after reset is accepted as a
  // low-to-high change and never produces a spurious press.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_key_n;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        r_cnt   <= '0;
        r_level <= r_sync2;
        r_press <= r_level & ~r_sync2;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_level = r_level;
  assign o_press = r_press;

endmodule

// File: rtl/rps_round_ctrl.sv
// rps_round_ctrl
// Round controller: debounces the start key, waits for the selected computer
// player, latches one choice per press, judges the round, keeps saturating
// scores and pulses round_done for one cycle.
// Optional feature macro: RPS_ROUND_TIMEOUT_EN -- WAIT_RDY gives up after
// TIMEOUT_CYCLES without re_ready and uses com_ra instead of com_re.
// Ports:
//   CLOCK_50, reset        clock, asynchronous active-low reset
//   start_n                raw start key (active-low)
//   user_choice, mode      user choice, player select
//   com_ra, com_m, com_re  random / Markov / reinforcement player choices
//   re_ready               reinforcement player has a valid choice
//   com_loaded,user_loaded latched choices
//   user_score, com_score  saturating scores
//   uwin, cwin, equ        last round outcome flags
//   round_done             one-cycle pulse when a round is judged
//   busy                   high whenever the FSM is not IDLE
module rps_round_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned SCORE_W         = 8,
  parameter int unsigned TIMEOUT_CYCLES  = 50000000
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic               start_n,
  input  logic [1:0]         user_choice,
  input  logic [1:0]         mode,
  input  logic [1:0]         com_ra,
  input  logic [1:0]         com_m,
  input  logic [1:0]         com_re,
  input  logic               re_ready,
  output logic [1:0]         com_loaded,
  output logic [1:0]         user_loaded,
  output logic [SCORE_W-1:0] user_score,
  output logic [SCORE_W-1:0] com_score,
  output logic               uwin,
  output logic               cwin,
  output logic               equ,
  output logic               round_done,
  output logic               busy
);

  import rps_pkg::*;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_key_level;
  logic               w_press;
  logic               w_rdy_ok;
  logic               w_timeout;
  logic               w_force_ra;
  logic [1:0]         w_com_sel;
  logic [1:0]         r_com;
  logic [1:0]         r_user;
  logic [SCORE_W-1:0] r_user_score;
  logic [SCORE_W-1:0] r_com_score;
  logic               r_uwin;
  logic               r_cwin;
  logic               r_equ;
  logic               r_round_done;

  key_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb (
    .CLOCK_50(CLOCK_50),
    .reset   (reset),
    .i_key_n (start_n),
    .o_level (w_key_level),
    .o_press (w_press)
  );

  assign w_rdy_ok = (mode != MODE_REINFORCE) || re_ready;

`ifdef RPS_ROUND_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TW-1:0] r_wait_cnt;
  logic          r_to;

  assign w_timeout = (r_state == S_WAIT_RDY) && (r_wait_cnt == TW'(TIMEOUT_CYCLES - 1));

  // Counter only runs inside WAIT_RDY, so it is zero on every entry.
  // r_to remembers that LATCH was reached by timeout rather than by re_ready.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      r_wait_cnt <= '0;
      r_to       <= 1'b0;
    end else begin
      r_wait_cnt <= (r_state == S_WAIT_RDY) ? r_wait_cnt + TW'(1) : '0;
      if (r_state == S_WAIT_RDY) r_to <= w_timeout && !w_rdy_ok;
      else if (r_state == S_IDLE) r_to <= 1'b0;
    end
  end

  assign w_force_ra = r_to;
`else
  assign w_timeout  = 1'b0;
  assign w_force_ra = 1'b0;
`endif

  always_comb begin
    w_com_sel = com_ra;
    case (mode_t'(mode))
      MODE_MARKOV:    w_com_sel = com_m;
      MODE_REINFORCE: w_com_sel = w_force_ra ? com_ra : com_re;
      default:        w_com_sel = com_ra;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = (r_state != S_IDLE);
    case (r_state)
      S_IDLE:     if (w_press) w_state_nxt = S_WAIT_RDY;
      S_WAIT_RDY: if (w_rdy_ok || w_timeout) w_state_nxt = S_LATCH;
      S_LATCH:    w_state_nxt = S_JUDGE;
      S_JUDGE:    w_state_nxt = S_HOLD;
      S_HOLD:     if (w_key_level) w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      r_com        <= '0;
      r_user       <= '0;
      r_user_score <= '0;
      r_com_score  <= '0;
      r_uwin       <= 1'b0;
      r_cwin       <= 1'b0;
      r_equ        <= 1'b0;
      r_round_done <= 1'b0;
    end else begin
      r_round_done <= 1'b0;
      case (r_state)
        S_LATCH: begin
          r_com  <= w_com_sel;
          r_user <= user_choice;
          r_uwin <= 1'b0;
          r_cwin <= 1'b0;
          r_equ  <= 1'b0;
        end
        S_JUDGE: begin
          r_round_done <= 1'b1;
          case (judge(r_user, r_com))
            OUT_WIN: begin
              r_uwin <= 1'b1;
              if (r_user_score != '1) r_user_score <= r_user_score + SCORE_W'(1);
            end
            OUT_LOSE: begin
              r_cwin <= 1'b1;
              if (r_com_score != '1) r_com_score <= r_com_score + SCORE_W'(1);
            end
            OUT_DRAW: r_equ <= 1'b1;
            default:  ;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign com_loaded  = r_com;
  assign user_loaded = r_user;
  assign user_score  = r_user_score;
  assign com_score   = r_com_score;
  assign uwin        = r_uwin;
  assign cwin        = r_cwin;
  assign equ         = r_equ;
  assign round_done  = r_round_done;

endmodule

// File: tb/tb_rps_round_ctrl.sv
`timescale 1ns/1ps
module tb_rps_round_ctrl;

  localparam int D  = 4;
  localparam int SW = 8;
  localparam int TO = 10;
  localparam int LAT = 2 + D + 4;

  logic          CLOCK_50 = 1'b0;
  logic          reset = 1'b0;
  logic          start_n = 1'b1;
  logic [1:0]    user_choice = 2'd0, mode = 2'd0;
  logic [1:0]    com_ra = 2'd0, com_m = 2'd0, com_re = 2'd0;
  logic          re_ready = 1'b0;
  logic [1:0]    com_loaded, user_loaded;
  logic [SW-1:0] user_score, com_score;
  logic          uwin, cwin, equ, round_done, busy;

  rps_round_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .SCORE_W        (SW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .start_n    (start_n),
    .user_choice(user_choice),
    .mode       (mode),
    .com_ra     (com_ra),
    .com_m      (com_m),
    .com_re     (com_re),
    .re_ready   (re_ready),
    .com_loaded (com_loaded),
    .user_loaded(user_loaded),
    .user_score (user_score),
    .com_score  (com_score),
    .uwin       (uwin),
    .cwin       (cwin),
    .equ        (equ),
    .round_done (round_done),
    .busy       (busy)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int checks = 0;
  int failures = 0;

  // cycle stamp and round_done monitor (sampled on the falling edge)
  int   cyc = 0;
  int   rd_count = 0;
  int   rd_last = 0;
  int   rd_wide = 0;
  logic rd_prev = 1'b0;
  always @(posedge CLOCK_50) cyc = cyc + 1;
  always @(negedge CLOCK_50) begin
    if (round_done === 1'b1) begin
      rd_count = rd_count + 1;
      rd_last  = cyc;
      if (rd_prev === 1'b1) rd_wide = rd_wide + 1;
    end
    rd_prev = round_done;
  end

  // reference model: state after the last judged round
  int         exp_us = 0, exp_cs = 0;
  logic [2:0] exp_flags = 3'b000;   // {uwin,cwin,equ}
  logic [1:0] exp_com = 2'd0, exp_user = 2'd0;

  function automatic void model_reset();
    exp_us = 0; exp_cs = 0; exp_flags = 3'b000; exp_com = 2'd0; exp_user = 2'd0;
  endfunction

  // Outcome from the game rules: each valid choice c defeats (c+1) mod 3.
  function automatic void model_round(input logic [1:0] u, input logic [1:0] m,
                                      input logic [1:0] ra, input logic [1:0] mk,
                                      input logic [1:0] re, input bit force_ra);
    int ui, ci;
    logic [1:0] c;
    if (m == 2'd1)                 c = mk;
    else if (m == 2'd2 && !force_ra) c = re;
    else                           c = ra;
    exp_com = c; exp_user = u;
    ui = int'(u); ci = int'(c);
    if (ui == 3 || ci == 3) exp_flags = 3'b000;
    else if (ui == ci) exp_flags = 3'b001;
    else if ((ui + 1) % 3 == ci) begin
      exp_flags = 3'b100;
      if (exp_us < (1 << SW) - 1) exp_us++;
    end else begin
      exp_flags = 3'b010;
      if (exp_cs < (1 << SW) - 1) exp_cs++;
    end
  endfunction

  task automatic key_press(input int hold, output int t_fall);
    @(negedge CLOCK_50);
    start_n = 1'b0;
    t_fall  = cyc;
    repeat (hold) @(negedge CLOCK_50);
    start_n = 1'b1;
  endtask

  task automatic settle();
    repeat (D + 10) @(negedge CLOCK_50);
  endtask

  task automatic test_reset();
    logic [24:0] got;
    reset = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    got = {com_loaded, user_loaded, user_score, com_score, uwin, cwin, equ, round_done, busy};
    checks++;
    if (got !== 25'd0) begin
      failures++;
      $display("FAIL reset_outputs: got %h expected 0", got);
    end
    reset = 1'b1;
    settle();
    checks++;
    if (busy !== 1'b0 || rd_count !== 0) begin
      failures++;
      $display("FAIL reset_idle: busy=%b rounds=%0d expected busy=0 rounds=0", busy, rd_count);
    end
    model_reset();
  endtask

  task automatic test_basic_win();
    int tf, rd0;
    mode = 2'd0; com_ra = 2'd1; user_choice = 2'd0; com_m = 2'd2; com_re = 2'd2;
    rd0 = rd_count;
    key_press(8, tf);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL basic_busy: got %b expected 1", busy);
    end
    model_round(user_choice, mode, com_ra, com_m, com_re, 1'b0);
    settle();
    checks++;
    if (rd_count - rd0 !== 1) begin
      failures++;
      $display("FAIL basic_pulses: got %0d expected 1", rd_count - rd0);
    end
    checks++;
    if (rd_last - tf !== LAT) begin
      failures++;
      $display("FAIL basic_latency: got %0d expected %0d", rd_last - tf, LAT);
    end
    checks++;
    if ({uwin, cwin, equ} !== exp_flags || user_score !== SW'(exp_us) || com_score !== SW'(exp_cs)) begin
      failures++;
      $display("FAIL basic_result: flags=%b us=%0d cs=%0d expected flags=%b us=%0d cs=%0d",
               {uwin, cwin, equ}, user_score, com_score, exp_flags, exp_us, exp_cs);
    end
    checks++;
    if (com_loaded !== exp_com || user_loaded !== exp_user || busy !== 1'b0) begin
      failures++;
      $display("FAIL basic_loaded: com=%0d user=%0d busy=%b expected com=%0d user=%0d busy=0",
               com_loaded, user_loaded, busy, exp_com, exp_user);
    end
  endtask

  task automatic test_wait_ready();
    int tf, rd0;
    mode = 2'd2; re_ready = 1'b0; com_re = 2'd2; com_ra = 2'd1; com_m = 2'd1; user_choice = 2'd0;
    rd0 = rd_count;
    key_press(8, tf);
    repeat (20) @(negedge CLOCK_50);
    checks++;
    if (busy !== 1'b1 || rd_count !== rd0) begin
      failures++;
      $display("FAIL wait_stall: busy=%b rounds=%0d expected busy=1 rounds=0", busy, rd_count - rd0);
    end
    // a press while busy must be dropped
    key_press(8, tf);
    repeat (12) @(negedge CLOCK_50);
    re_ready = 1'b1;
    model_round(user_choice, mode, com_ra, com_m, com_re, 1'b0);
    settle();
    settle();
    checks++;
    if (rd_count - rd0 !== 1) begin
      failures++;
      $display("FAIL wait_pulses: got %0d expected 1", rd_count - rd0);
    end
    checks++;
    if ({uwin, cwin, equ} !== exp_flags || com_score !== SW'(exp_cs) || user_score !== SW'(exp_us)
        || com_loaded !== exp_com) begin
      failures++;
      $display("FAIL wait_result: flags=%b us=%0d cs=%0d com=%0d expected flags=%b us=%0d cs=%0d com=%0d",
               {uwin, cwin, equ}, user_score, com_score, com_loaded, exp_flags, exp_us, exp_cs, exp_com);
    end
  endtask

  task automatic test_invalid();
    int tf, rd0;
    for (int k = 0; k < 2; k++) begin
      re_ready = 1'b1;
      mode = 2'd0; com_m = 2'd0; com_re = 2'd0;
      if (k == 0) begin user_choice = 2'd3; com_ra = 2'd1; end
      else        begin user_choice = 2'd0; com_ra = 2'd3; end
      rd0 = rd_count;
      key_press(8, tf);
      model_round(user_choice, mode, com_ra, com_m, com_re, 1'b0);
      settle();
      checks++;
      if (rd_count - rd0 !== 1 || {uwin, cwin, equ} !== exp_flags
          || user_score !== SW'(exp_us) || com_score !== SW'(exp_cs)) begin
        failures++;
        $display("FAIL invalid_%0d: pulses=%0d flags=%b us=%0d cs=%0d expected pulses=1 flags=%b us=%0d cs=%0d",
                 k, rd_count - rd0, {uwin, cwin, equ}, user_score, com_score, exp_flags, exp_us, exp_cs);
      end
    end
  endtask

  task automatic test_random();
    int tf, rd0;
    for (int r = 0; r < 40; r++) begin
      user_choice = 2'($urandom_range(0, 3));
      mode        = 2'($urandom_range(0, 3));
      com_ra      = 2'($urandom_range(0, 3));
      com_m       = 2'($urandom_range(0, 3));
      com_re      = 2'($urandom_range(0, 3));
      re_ready    = 1'b1;
      rd0 = rd_count;
      key_press(int'($urandom_range(6, 15)), tf);
      model_round(user_choice, mode, com_ra, com_m, com_re, 1'b0);
      settle();
      checks++;
      if (rd_count - rd0 !== 1 || rd_last - tf !== LAT || {uwin, cwin, equ} !== exp_flags
          || user_score !== SW'(exp_us) || com_score !== SW'(exp_cs)
          || com_loaded !== exp_com || user_loaded !== exp_user) begin
        failures++;
        $display("FAIL random_%0d: pulses=%0d lat=%0d flags=%b us=%0d cs=%0d com=%0d user=%0d expected pulses=1 lat=%0d flags=%b us=%0d cs=%0d com=%0d user=%0d",
                 r, rd_count - rd0, rd_last - tf, {uwin, cwin, equ}, user_score, com_score,
                 com_loaded, user_loaded, LAT, exp_flags, exp_us, exp_cs, exp_com, exp_user);
      end
    end
  endtask

  task automatic test_saturation();
    int tf, rd0, n;
    mode = 2'd0; user_choice = 2'd0; com_ra = 2'd1;
    rd0 = rd_count;
    n = 0;
    for (int i = 0; i < 300 && exp_us < 255; i++) begin
      key_press(6, tf);
      model_round(user_choice, mode, com_ra, com_m, com_re, 1'b0);
      settle();
      n++;
    end
    checks++;
    if (user_score !== 8'd255 || rd_count - rd0 !== n) begin
      failures++;
      $display("FAIL sat_fill: us=%0d pulses=%0d expected us=255 pulses=%0d", user_score, rd_count - rd0, n);
    end
    key_press(6, tf);
    model_round(user_choice, mode, com_ra, com_m, com_re, 1'b0);
    settle();
    checks++;
    if (user_score !== SW'(exp_us) || uwin !== 1'b1 || exp_us != 255) begin
      failures++;
      $display("FAIL sat_hold: us=%0d uwin=%b expected us=255 uwin=1", user_score, uwin);
    end
  endtask

  task automatic test_glitch_hold();
    int tf, rd0;
    mode = 2'd1; com_m = 2'd0; user_choice = 2'd1; com_ra = 2'd2;
    rd0 = rd_count;
    key_press(1000, tf);
    for (int g = 0; g < 4; g++) begin
      start_n = 1'b1;
      repeat (3) @(negedge CLOCK_50);
      start_n = 1'b0;
      repeat (3) @(negedge CLOCK_50);
    end
    checks++;
    if (busy !== 1'b1 || rd_count - rd0 !== 1) begin
      failures++;
      $display("FAIL glitch_hold: busy=%b pulses=%0d expected busy=1 pulses=1", busy, rd_count - rd0);
    end
    start_n = 1'b1;
    model_round(user_choice, mode, com_ra, com_m, com_re, 1'b0);
    settle();
    checks++;
    if (rd_count - rd0 !== 1 || busy !== 1'b0 || {uwin, cwin, equ} !== exp_flags
        || com_score !== SW'(exp_cs)) begin
      failures++;
      $display("FAIL glitch_result: pulses=%0d busy=%b flags=%b cs=%0d expected pulses=1 busy=0 flags=%b cs=%0d",
               rd_count - rd0, busy, {uwin, cwin, equ}, com_score, exp_flags, exp_cs);
    end
    checks++;
    if (rd_wide !== 0) begin
      failures++;
      $display("FAIL pulse_width: wide pulses=%0d expected 0", rd_wide);
    end
  endtask

  task automatic test_reset_mid_round();
    int tf, rd0;
    logic [24:0] got;
    mode = 2'd0; com_ra = 2'd2; user_choice = 2'd1;
    rd0 = rd_count;
    @(negedge CLOCK_50);
    start_n = 1'b0;
    tf = cyc;
    repeat (9) @(negedge CLOCK_50);
    // now in JUDGE: choices already latched
    checks++;
    if (com_loaded !== 2'd2 || user_loaded !== 2'd1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL mid_latched: com=%0d user=%0d busy=%b expected com=2 user=1 busy=1",
               com_loaded, user_loaded, busy);
    end
    reset = 1'b0;
    #1;
    got = {com_loaded, user_loaded, user_score, com_score, uwin, cwin, equ, round_done, busy};
    checks++;
    if (got !== 25'd0) begin
      failures++;
      $display("FAIL mid_reset_outputs: got %h expected 0", got);
    end
    repeat (3) @(negedge CLOCK_50);
    reset = 1'b1;
    repeat (5) @(negedge CLOCK_50);
    start_n = 1'b1;
    settle();
    model_reset();
    got = {com_loaded, user_loaded, user_score, com_score, uwin, cwin, equ, round_done, busy};
    checks++;
    if (got !== 25'd0 || rd_count !== rd0) begin
      failures++;
      $display("FAIL mid_reset_after: outputs=%h pulses=%0d expected 0 and 0", got, rd_count - rd0);
    end
  endtask

`ifdef RPS_ROUND_TIMEOUT_EN
  task automatic test_timeout();
    int tf, rd0;
    mode = 2'd2; re_ready = 1'b0; com_ra = 2'd0; com_re = 2'd1; com_m = 2'd1; user_choice = 2'd2;
    rd0 = rd_count;
    key_press(8, tf);
    model_round(user_choice, mode, com_ra, com_m, com_re, 1'b1);
    repeat (TO + 20) @(negedge CLOCK_50);
    checks++;
    if (rd_count - rd0 !== 1 || uwin !== 1'b1 || com_loaded !== exp_com || user_score !== SW'(exp_us)) begin
      failures++;
      $display("FAIL timeout_round: pulses=%0d uwin=%b com=%0d us=%0d expected pulses=1 uwin=1 com=%0d us=%0d",
               rd_count - rd0, uwin, com_loaded, user_score, exp_com, exp_us);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_win();
    test_wait_ready();
    test_invalid();
    test_random();
    test_saturation();
    test_glitch_hold();
    test_reset_mid_round();
`ifdef RPS_ROUND_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
